// File: rtl/posit_fir_decoder_seq.sv
// Iterative posit-to-FIR decoder: one posit in, sign / total exponent / mantissa out on a held handshake.
// Define DEC_FAST_SCAN_EN to resolve the regime in one cycle with a combinational leading-run counter.
module posit_fir_decoder_seq #(
    parameter int N         = 16,
    parameter int ES        = 1,
    parameter int TE_BITS   = 8,
    parameter int MANT_SIZE = N - ES - 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [N-1:0]              posit_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      sign_o,
    output logic signed [TE_BITS-1:0] te_o,
    output logic [MANT_SIZE-1:0]      mant_o,
    output logic                      is_zero_o,
    output logic                      is_nar_o
);

    localparam int SR_W  = N - 1;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] K_MAX = CNT_W'(SR_W);

    typedef enum logic [1:0] {IDLE, SCAN, EXTRACT, HOLD} state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic              r0;
    logic [CNT_W-1:0]  cnt;
    logic              sign_q;
    logic [N-1:0]      mag;
    logic              in_zero;
    logic              in_nar;

    assign mag        = posit_i[N-1] ? -posit_i : posit_i;
    assign in_zero    = (posit_i == '0);
    assign in_nar     = (posit_i == {1'b1, {(N-1){1'b0}}});
    assign in_ready_o = (state == IDLE) && !rst_i;

    // te = regime * 2^ES + exponent, regime = k-1 for a run of ones, -k for a run of zeros
    function automatic logic signed [TE_BITS-1:0] calc_te(input logic r0_f,
                                                           input logic [CNT_W-1:0] k,
                                                           input logic [ES-1:0] e);
        logic signed [TE_BITS-1:0] kx;
        logic signed [TE_BITS-1:0] ex;
        logic signed [TE_BITS-1:0] regime;
        kx     = signed'(TE_BITS'(k));
        ex     = signed'(TE_BITS'(e));
        regime = r0_f ? (kx - TE_BITS'(1)) : -kx;
        return (regime <<< ES) + ex;
    endfunction

`ifdef DEC_FAST_SCAN_EN
    function automatic logic [CNT_W-1:0] lead_run(input logic [SR_W-1:0] v, input logic b);
        logic [CNT_W-1:0] n;
        logic             done;
        n    = '0;
        done = 1'b0;
        for (int i = SR_W - 1; i >= 0; i--) begin
            if (!done && (v[i] == b)) n = n + 1'b1;
            else                      done = 1'b1;
        end
        return n;
    endfunction

    logic [CNT_W-1:0] run_len;
    assign run_len = lead_run(sr, r0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            sign_o      <= 1'b0;
            te_o        <= '0;
            mant_o      <= '0;
            is_zero_o   <= 1'b0;
            is_nar_o    <= 1'b0;
            sr          <= '0;
            r0          <= 1'b0;
            cnt         <= '0;
            sign_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        if (in_zero || in_nar) begin
                            is_zero_o   <= in_zero;
                            is_nar_o    <= in_nar;
                            sign_o      <= 1'b0;
                            te_o        <= '0;
                            mant_o      <= '0;
                            out_valid_o <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            sign_q <= posit_i[N-1];
                            sr     <= mag[N-2:0];
                            r0     <= mag[N-2];
                            cnt    <= '0;
                            state  <= SCAN;
                        end
                    end
                end
                SCAN: begin
`ifdef DEC_FAST_SCAN_EN
                    cnt   <= run_len;
                    // An exhausted regime leaves nothing behind it; otherwise drop run plus terminator
                    sr    <= (run_len == K_MAX) ? '0 : (sr << (run_len + 1'b1));
                    state <= EXTRACT;
`else
                    sr <= sr << 1;
                    if (sr[SR_W-1] == r0) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == K_MAX - 1'b1) state <= EXTRACT;
                    end else begin
                        state <= EXTRACT;
                    end
`endif
                end
                EXTRACT: begin
                    sign_o      <= sign_q;
                    te_o        <= calc_te(r0, cnt, sr[SR_W-1 -: ES]);
                    mant_o      <= {1'b1, sr[SR_W-1-ES -: MANT_SIZE-1]};
                    is_zero_o   <= 1'b0;
                    is_nar_o    <= 1'b0;
                    out_valid_o <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_fir_decoder_seq.sv
// Self-checking bench for posit_fir_decoder_seq: directed vector table, hand sequences, random vs reference model.
module tb_posit_fir_decoder_seq;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int TE_BITS = 8;
    localparam int MANT_SIZE = N - ES - 2;

    logic                      clk = 1'b0;
    logic                      rst_i = 1'b1;
    logic                      in_valid_i = 1'b0;
    logic                      in_ready_o;
    logic [N-1:0]              posit_i = '0;
    logic                      out_valid_o;
    logic                      out_ready_i = 1'b0;
    logic                      sign_o;
    logic signed [TE_BITS-1:0] te_o;
    logic [MANT_SIZE-1:0]      mant_o;
    logic                      is_zero_o;
    logic                      is_nar_o;

    int n_chk  = 0;
    int n_fail = 0;

    posit_fir_decoder_seq #(.N(N), .ES(ES), .TE_BITS(TE_BITS), .MANT_SIZE(MANT_SIZE)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .posit_i(posit_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sign_o(sign_o), .te_o(te_o), .mant_o(mant_o),
        .is_zero_o(is_zero_o), .is_nar_o(is_nar_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] p;
        logic         sign;
        int           te;
        int           mant;
        logic         zero;
        logic         nar;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference decode straight from the posit definition, walking the bit string by position
    function automatic vec_t model(input logic [N-1:0] p);
        vec_t e;
        logic [N-1:0] m;
        int idx, k, regime, expo, frac;
        logic r0;
        e.p = p; e.sign = 0; e.te = 0; e.mant = 0; e.zero = 0; e.nar = 0; e.lat = 1;
        if (p == 0) begin
            e.zero = 1;
        end else if (p == (1 << (N-1))) begin
            e.nar = 1;
        end else begin
            e.sign = p[N-1];
            m = p[N-1] ? -p : p;
            idx = N - 2;
            r0 = m[N-2];
            k = 0;
            while (idx >= 0 && m[idx] == r0) begin k++; idx--; end
            if (idx >= 0) idx--;
            regime = r0 ? k - 1 : -k;
            expo = 0;
            for (int j = 0; j < ES; j++) begin
                expo = expo * 2 + ((idx >= 0) ? int'(m[idx]) : 0);
                idx--;
            end
            frac = 0;
            for (int j = 0; j < MANT_SIZE - 1; j++) begin
                frac = frac * 2 + ((idx >= 0) ? int'(m[idx]) : 0);
                idx--;
            end
            e.te = regime * (1 << ES) + expo;
            e.mant = (1 << (MANT_SIZE - 1)) + frac;
`ifdef DEC_FAST_SCAN_EN
            e.lat = 3;
`else
            e.lat = (k == N - 1) ? N + 1 : k + 3;
`endif
        end
        return e;
    endfunction

    // Called at posedge+1 with the DUT idle; returns edges from acceptance to out_valid_o
    task automatic run_op(input logic [N-1:0] p, output int lat);
        in_valid_i = 1'b1;
        posit_i = p;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic check_op(input string name, input vec_t e);
        int lat;
        run_op(e.p, lat);
        chk({name, " latency"}, lat, e.lat);
        chk({name, " valid"}, out_valid_o, 1);
        chk({name, " sign"}, sign_o, e.sign);
        chk({name, " te"}, $signed(te_o), e.te);
        chk({name, " mant"}, mant_o, e.mant);
        chk({name, " zero"}, is_zero_o, e.zero);
        chk({name, " nar"}, is_nar_o, e.nar);
        release_out();
    endtask

    function automatic int nz_lat(input int iter_lat);
`ifdef DEC_FAST_SCAN_EN
        return 3;
`else
        return iter_lat;
`endif
    endfunction

    vec_t vecs[$];

    initial begin
        int lat;
        int seen;
        logic [N-1:0] rp;

        vecs.push_back('{16'h4000, 1'b0,   0, 'h1000, 1'b0, 1'b0, nz_lat(4)});
        vecs.push_back('{16'hC000, 1'b1,   0, 'h1000, 1'b0, 1'b0, nz_lat(4)});
        vecs.push_back('{16'h4800, 1'b0,   0, 'h1800, 1'b0, 1'b0, nz_lat(4)});
        vecs.push_back('{16'h5000, 1'b0,   1, 'h1000, 1'b0, 1'b0, nz_lat(4)});
        vecs.push_back('{16'h6000, 1'b0,   2, 'h1000, 1'b0, 1'b0, nz_lat(5)});
        vecs.push_back('{16'h2000, 1'b0,  -2, 'h1000, 1'b0, 1'b0, nz_lat(4)});
        vecs.push_back('{16'h7FFF, 1'b0,  28, 'h1000, 1'b0, 1'b0, nz_lat(17)});
        vecs.push_back('{16'h0001, 1'b0, -28, 'h1000, 1'b0, 1'b0, nz_lat(17)});
        vecs.push_back('{16'h0000, 1'b0,   0, 0,      1'b1, 1'b0, 1});
        vecs.push_back('{16'h8000, 1'b0,   0, 0,      1'b0, 1'b1, 1});

        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready_o, 0);
        chk("reset out_valid", out_valid_o, 0);
        chk("reset te", $signed(te_o), 0);
        chk("reset mant", mant_o, 0);
        chk("reset flags", {is_zero_o, is_nar_o, sign_o}, 0);
        rst_i = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", in_ready_o, 1);

        foreach (vecs[i]) check_op($sformatf("vec%0d_%04h", i, vecs[i].p), vecs[i]);

        // Backpressure: outputs held, new input ignored
        run_op(16'h5000, lat);
        in_valid_i = 1'b1;
        posit_i = 16'h7FFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d valid", c), out_valid_o, 1);
            chk($sformatf("bp%0d te", c), $signed(te_o), 1);
            chk($sformatf("bp%0d mant", c), mant_o, 'h1000);
            chk($sformatf("bp%0d in_ready", c), in_ready_o, 0);
        end
        in_valid_i = 1'b0;
        release_out();
        chk("bp release in_ready", in_ready_o, 1);
        chk("bp release valid", out_valid_o, 0);

        // Reset pulsed mid-scan discards the operand
        in_valid_i = 1'b1;
        posit_i = 16'h7FFF;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        #1;
        chk("rst pulse in_ready low", in_ready_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 24; c++) begin
            if (out_valid_o) seen++;
            @(posedge clk); #1;
        end
        chk("rst scan no valid", seen, 0);
        chk("rst scan idle", in_ready_o, 1);

        // Random operands against the reference model
        for (int i = 0; i < 200; i++) begin
            rp = N'($urandom);
            if (i % 17 == 0) rp = N'($urandom_range(0, 3));
            if (i % 23 == 0) rp = ~N'($urandom_range(0, 3));
            check_op($sformatf("rnd%0d_%04h", i, rp), model(rp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
